// File: rtl/execute.sv
// Execute stage for a 4-bit accumulator-style core.
// Each accepted word is one of three kinds: a jump, a register write, or an
// output-port write. The input port is synchronized before use.
module execute (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [3:0] im,
  input  logic       is_imm,
  input  logic       mem_w,
  input  logic       is_jump,
  input  logic       is_jnc,
  input  logic       is_add,
  input  logic       is_in,
  input  logic       s_reg,
  input  logic [3:0] operand,
  input  logic [3:0] in_port,
  output logic [3:0] result,
  output logic       in_mem_w,
  output logic       in_s_reg,
  output logic [3:0] pc,
  output logic       carry,
  output logic [3:0] out_port
);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_result;
  logic       r_mem_w;
  logic       r_s_reg;
  logic [3:0] r_pc;
  logic       r_carry;
  logic [3:0] r_out;

  logic [4:0] w_sum;
  logic [3:0] w_src;
  logic       w_write;
  logic       w_take_jump;
  logic       w_carry_next;
  logic [3:0] w_pc_inc;

  assign w_sum       = {1'b0, operand} + {1'b0, im};
  assign w_pc_inc    = r_pc + 4'd1;
  assign w_write     = dec_valid & mem_w & ~is_jump;
  assign w_take_jump = ~is_jnc | ~r_carry;

  // Source select for register writes; IN outranks ADD outranks immediate.
  always_comb begin
    w_src        = operand;
    w_carry_next = 1'b0;
    if (is_in) begin
      w_src = r_sync2;
    end else if (is_add) begin
      w_src        = w_sum[3:0];
      w_carry_next = w_sum[4];
    end else if (is_imm) begin
      w_src = im;
    end
  end

  // Two-flop synchronizer on the asynchronous input switches; runs every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Architectural state: jump has priority over write, write over output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
      r_mem_w  <= 1'b0;
      r_s_reg  <= 1'b0;
      r_pc     <= '0;
      r_carry  <= 1'b0;
      r_out    <= '0;
    end else begin
      r_mem_w <= w_write;
      if (dec_valid) begin
        if (is_jump) begin
          r_pc    <= w_take_jump ? im : w_pc_inc;
          r_carry <= 1'b0;
        end else if (mem_w) begin
          r_result <= w_src;
          r_s_reg  <= s_reg;
          r_pc     <= w_pc_inc;
          r_carry  <= w_carry_next;
        end else begin
          r_out   <= is_imm ? im : operand;
          r_pc    <= w_pc_inc;
          r_carry <= 1'b0;
        end
      end
    end
  end

  assign result   = r_result;
  assign in_mem_w = r_mem_w;
  assign in_s_reg = r_s_reg;
  assign pc       = r_pc;
  assign carry    = r_carry;
  assign out_port = r_out;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage with hand-computed expectations.
module tb_execute;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [3:0] im;
  logic       is_imm;
  logic       mem_w;
  logic       is_jump;
  logic       is_jnc;
  logic       is_add;
  logic       is_in;
  logic       s_reg;
  logic [3:0] operand;
  logic [3:0] in_port;
  logic [3:0] result;
  logic       in_mem_w;
  logic       in_s_reg;
  logic [3:0] pc;
  logic       carry;
  logic [3:0] out_port;

  int unsigned n_checks;
  int unsigned n_fails;

  execute dut (
    .clk      (clk),
    .rst      (rst),
    .dec_valid(dec_valid),
    .im       (im),
    .is_imm   (is_imm),
    .mem_w    (mem_w),
    .is_jump  (is_jump),
    .is_jnc   (is_jnc),
    .is_add   (is_add),
    .is_in    (is_in),
    .s_reg    (s_reg),
    .operand  (operand),
    .in_port  (in_port),
    .result   (result),
    .in_mem_w (in_mem_w),
    .in_s_reg (in_s_reg),
    .pc       (pc),
    .carry    (carry),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] r, input logic mw,
                             input logic sr, input logic [3:0] p, input logic c,
                             input logic [3:0] o);
    check_eq({tag, ".result"},   {4'd0, result},   {4'd0, r});
    check_eq({tag, ".in_mem_w"}, {7'd0, in_mem_w}, {7'd0, mw});
    check_eq({tag, ".in_s_reg"}, {7'd0, in_s_reg}, {7'd0, sr});
    check_eq({tag, ".pc"},       {4'd0, pc},       {4'd0, p});
    check_eq({tag, ".carry"},    {7'd0, carry},    {7'd0, c});
    check_eq({tag, ".out_port"}, {4'd0, out_port}, {4'd0, o});
  endtask

  // Present one decode word, then sample 1 time unit after the rising edge.
  task automatic issue(input logic dv, input logic jmp, input logic jnc, input logic mw,
                       input logic add, input logic inn, input logic imm, input logic sr,
                       input logic [3:0] i, input logic [3:0] op);
    dec_valid = dv;
    is_jump   = jmp;
    is_jnc    = jnc;
    mem_w     = mw;
    is_add    = add;
    is_in     = inn;
    is_imm    = imm;
    s_reg     = sr;
    im        = i;
    operand   = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    dec_valid = 1'b0;
    im        = '0;
    is_imm    = 1'b0;
    mem_w     = 1'b0;
    is_jump   = 1'b0;
    is_jnc    = 1'b0;
    is_add    = 1'b0;
    is_in     = 1'b0;
    s_reg     = 1'b0;
    operand   = '0;
    in_port   = '0;

    // Reset applied before any clock edge must clear everything.
    #1 rst = 1'b0;
    #2;
    check_state("reset_async", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    check_state("reset_held", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    //    dv jmp jnc mw add in imm sr  im     op
    issue(1, 0, 0, 1, 1, 0, 0, 1, 4'h8, 4'h9);   // ADD 9+8
    check_state("add_carry", 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h0);
    issue(1, 1, 1, 0, 0, 0, 0, 0, 4'h5, 4'h0);   // JNC with carry set
    check_state("jnc_not_taken", 4'h1, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0);
    issue(1, 0, 0, 1, 1, 0, 0, 1, 4'h1, 4'hF);   // ADD 15+1 sets carry
    check_state("add_wrap", 4'h0, 1'b1, 1'b1, 4'h3, 1'b1, 4'h0);
    issue(1, 0, 0, 1, 0, 0, 1, 0, 4'h3, 4'h0);   // MOV A,#3 clears carry
    check_state("mov_imm_b2b", 4'h3, 1'b1, 1'b0, 4'h4, 1'b0, 4'h0);
    issue(1, 1, 1, 0, 0, 0, 0, 0, 4'h5, 4'h0);   // JNC taken
    check_state("jnc_taken", 4'h3, 1'b0, 1'b0, 4'h5, 1'b0, 4'h0);
    issue(1, 1, 0, 1, 0, 0, 1, 1, 4'hE, 4'h7);   // JMP with mem_w: no writeback
    check_state("jmp_prio", 4'h3, 1'b0, 1'b0, 4'hE, 1'b0, 4'h0);
    issue(1, 0, 0, 0, 0, 0, 1, 0, 4'h6, 4'hF);   // OUT #6
    check_state("out_imm", 4'h3, 1'b0, 1'b0, 4'hF, 1'b0, 4'h6);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 4'h2, 4'h9);   // OUT operand, pc wraps
    check_state("out_reg_wrap", 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 4'h9);
    issue(0, 0, 0, 1, 1, 0, 0, 1, 4'h8, 4'h9);   // idle: nothing changes
    check_state("idle_hold", 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 4'h9);
    issue(1, 0, 0, 1, 0, 0, 0, 1, 4'h1, 4'hC);   // MOV B,operand
    check_state("mov_reg", 4'hC, 1'b1, 1'b1, 4'h1, 1'b0, 4'h9);
    issue(1, 0, 0, 1, 1, 1, 1, 0, 4'h8, 4'h9);   // IN outranks ADD and imm
    check_state("in_prio", 4'h0, 1'b1, 1'b0, 4'h2, 1'b0, 4'h9);
    issue(1, 0, 0, 1, 1, 0, 0, 0, 4'h4, 4'h3);   // ADD 3+4 no carry
    check_state("add_nocarry", 4'h7, 1'b1, 1'b0, 4'h3, 1'b0, 4'h9);

    // Input port change: used only on the third edge after the change.
    in_port = 4'hA;
    issue(1, 0, 0, 1, 0, 1, 0, 0, 4'h0, 4'h0);
    check_state("in_stage0", 4'h0, 1'b1, 1'b0, 4'h4, 1'b0, 4'h9);
    issue(1, 0, 0, 1, 0, 1, 0, 0, 4'h0, 4'h0);
    check_state("in_stage1", 4'h0, 1'b1, 1'b0, 4'h5, 1'b0, 4'h9);
    issue(1, 0, 0, 1, 0, 1, 0, 0, 4'h0, 4'h0);
    check_state("in_synced", 4'hA, 1'b1, 1'b0, 4'h6, 1'b0, 4'h9);

    // Reset pulsed between edges while a writeback is visible.
    issue(1, 0, 0, 1, 0, 0, 1, 1, 4'h5, 4'h0);
    check_state("pre_reset_write", 4'h5, 1'b1, 1'b1, 4'h7, 1'b0, 4'h9);
    #2 rst = 1'b0;
    #1;
    check_state("reset_mid", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    dec_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_reset_idle", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    // Synchronizer was cleared: first IN after reset sees 0, next sees 0xA.
    issue(1, 0, 0, 1, 0, 1, 0, 1, 4'h0, 4'h0);
    check_state("in_after_reset", 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0);
    issue(1, 0, 0, 1, 0, 1, 0, 1, 4'h0, 4'h0);
    check_state("in_after_reset2", 4'hA, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0);

    // First edge after release accepts an instruction; 16 OUTs wrap pc to 0.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      issue(1, 0, 0, 0, 0, 0, 1, 0, 4'(k), 4'h0);
      check_eq("wrap_pc", {4'd0, pc}, 8'(((k + 1) % 16)));
    end
    check_eq("wrap_out", {4'd0, out_port}, 8'h0F);
    check_eq("wrap_mem_w", {7'd0, in_mem_w}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
